// File: rtl/master_arbiter.sv
// master_arbiter: two-master round-robin bus arbiter with idle timeout.
// Grants come from registered state; bus routing is purely combinational.
module master_arbiter #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rstn,
   input  logic m1_breq,
   input  logic m2_breq,
   output logic m1_bgrant,
   output logic m2_bgrant,
   input  logic m1_mode,
   input  logic m1_wr_bus,
   input  logic m1_master_valid,
   input  logic m1_master_ready,
   output logic m1_rd_bus,
   output logic m1_slave_ready,
   output logic m1_slave_valid,
   input  logic m2_mode,
   input  logic m2_wr_bus,
   input  logic m2_master_valid,
   input  logic m2_master_ready,
   output logic m2_rd_bus,
   output logic m2_slave_ready,
   output logic m2_slave_valid,
   output logic d_mode,
   output logic d_wr_bus,
   output logic d_master_valid,
   output logic d_master_ready,
   input  logic d_rd_bus,
   input  logic d_slave_ready,
   input  logic d_slave_valid,
   output logic owner,
   output logic timeout_err
);

   typedef enum logic [1:0] {
      IDLE,
      GRANTED,
      RELEASE
   } state_t;

   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYC - 1);

   state_t     state_q, state_d;
   logic       owner_q, owner_d;
   logic       last_q, last_d;
   logic       terr_q, terr_d;
   logic [7:0] cnt_q, cnt_d;
   logic [1:0] blk_q, blk_d;

   logic [1:0] breq;
   logic [1:0] elig;
   logic       own_act;
   logic       gnt;

   assign breq = {m2_breq, m1_breq};
   // a master revoked by timeout stays ineligible until it drops breq
   assign elig = breq & ~blk_q;

   assign own_act = d_slave_valid
                  | d_slave_ready
                  | (owner_q ? (m2_master_valid | m2_master_ready)
                             : (m1_master_valid | m1_master_ready));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         terr_q  <= 1'b0;
         cnt_q   <= '0;
         blk_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         terr_q  <= terr_d;
         cnt_q   <= cnt_d;
         blk_q   <= blk_d;
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      terr_d  = 1'b0;
      cnt_d   = cnt_q;
      blk_d   = blk_q & breq;
      unique case (state_q)
         IDLE: begin
            if (elig != 2'b00) begin
               state_d = GRANTED;
               cnt_d   = '0;
               if (elig == 2'b11)
                  owner_d = ~last_q;
               else
                  owner_d = elig[1];
            end
         end
         GRANTED: begin
            if (!breq[owner_q]) begin
               state_d = RELEASE;
               last_d  = owner_q;
            end else if (own_act) begin
               cnt_d = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d        = RELEASE;
               last_d         = owner_q;
               terr_d         = 1'b1;
               cnt_d          = '0;
               blk_d[owner_q] = 1'b1;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         RELEASE: begin
            if (elig[~owner_q]) begin
               state_d = GRANTED;
               owner_d = ~owner_q;
               cnt_d   = '0;
            end else if (elig[owner_q]) begin
               state_d = GRANTED;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign gnt = (state_q == GRANTED);

   assign m1_bgrant   = gnt & ~owner_q;
   assign m2_bgrant   = gnt & owner_q;
   assign owner       = owner_q;
   assign timeout_err = terr_q;

   assign d_mode         = gnt & (owner_q ? m2_mode : m1_mode);
   assign d_wr_bus       = gnt & (owner_q ? m2_wr_bus : m1_wr_bus);
   assign d_master_valid = gnt & (owner_q ? m2_master_valid
                                          : m1_master_valid);
   assign d_master_ready = gnt & (owner_q ? m2_master_ready
                                          : m1_master_ready);

   assign m1_rd_bus      = m1_bgrant & d_rd_bus;
   assign m1_slave_ready = m1_bgrant & d_slave_ready;
   assign m1_slave_valid = m1_bgrant & d_slave_valid;
   assign m2_rd_bus      = m2_bgrant & d_rd_bus;
   assign m2_slave_ready = m2_bgrant & d_slave_ready;
   assign m2_slave_valid = m2_bgrant & d_slave_valid;

endmodule

// File: tb/tb_master_arbiter.sv
// tb_master_arbiter: directed scenarios plus random traffic
// checked against a cycle-level behavioural model of the arbiter.
module tb_master_arbiter;

   localparam int TO = 8;

   logic clk = 1'b0;
   logic rstn;
   logic m1_breq, m2_breq, m1_bgrant, m2_bgrant;
   logic m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready;
   logic m1_rd_bus, m1_slave_ready, m1_slave_valid;
   logic m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready;
   logic m2_rd_bus, m2_slave_ready, m2_slave_valid;
   logic d_mode, d_wr_bus, d_master_valid, d_master_ready;
   logic d_rd_bus, d_slave_ready, d_slave_valid;
   logic owner, timeout_err;

   always #5 clk = ~clk;

   master_arbiter #(.TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rstn(rstn),
      .m1_breq(m1_breq), .m2_breq(m2_breq),
      .m1_bgrant(m1_bgrant), .m2_bgrant(m2_bgrant),
      .m1_mode(m1_mode), .m1_wr_bus(m1_wr_bus),
      .m1_master_valid(m1_master_valid),
      .m1_master_ready(m1_master_ready),
      .m1_rd_bus(m1_rd_bus), .m1_slave_ready(m1_slave_ready),
      .m1_slave_valid(m1_slave_valid),
      .m2_mode(m2_mode), .m2_wr_bus(m2_wr_bus),
      .m2_master_valid(m2_master_valid),
      .m2_master_ready(m2_master_ready),
      .m2_rd_bus(m2_rd_bus), .m2_slave_ready(m2_slave_ready),
      .m2_slave_valid(m2_slave_valid),
      .d_mode(d_mode), .d_wr_bus(d_wr_bus),
      .d_master_valid(d_master_valid),
      .d_master_ready(d_master_ready),
      .d_rd_bus(d_rd_bus), .d_slave_ready(d_slave_ready),
      .d_slave_valid(d_slave_valid),
      .owner(owner), .timeout_err(timeout_err)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // reference model: who holds the bus, whether a release gap is pending
   int holder;
   bit rel;
   int own_m, last_m, idle_m;
   bit terr_m;
   bit blk_m[2];

   task automatic model_reset();
      holder = -1; rel = 0; own_m = 0; last_m = 1;
      idle_m = 0; terr_m = 0; blk_m[0] = 0; blk_m[1] = 0;
   endtask

   task automatic grant(input int m);
      holder = m; own_m = m; idle_m = 0;
   endtask

   task automatic model_step();
      bit b[2];
      bit act, e0, e1;
      int rev, o;
      b[0] = m1_breq; b[1] = m2_breq;
      act = d_slave_valid | d_slave_ready |
            ((own_m == 1) ? (m2_master_valid | m2_master_ready)
                          : (m1_master_valid | m1_master_ready));
      rev = -1; terr_m = 0;
      if (rel) begin
         rel = 0; o = 1 - own_m;
         if (b[o] && !blk_m[o]) grant(o);
         else if (b[own_m] && !blk_m[own_m]) grant(own_m);
      end else if (holder >= 0) begin
         if (!b[holder]) begin
            last_m = own_m; holder = -1; rel = 1;
         end else if (act) begin
            idle_m = 0;
         end else if (idle_m == TO - 1) begin
            last_m = own_m; rev = holder; holder = -1;
            rel = 1; terr_m = 1;
         end else begin
            idle_m++;
         end
      end else begin
         e0 = b[0] && !blk_m[0];
         e1 = b[1] && !blk_m[1];
         if (e0 && e1) grant(1 - last_m);
         else if (e0) grant(0);
         else if (e1) grant(1);
      end
      for (int i = 0; i < 2; i++) if (!b[i]) blk_m[i] = 0;
      if (rev >= 0) blk_m[rev] = 1;
   endtask

   // stim: [12]m1_breq [11]m2_breq [10:7]m1 mode,wr,mv,mr
   //       [6:3]m2 mode,wr,mv,mr [2:0]d rd,sr,sv
   task automatic drive(input logic [12:0] s);
      {m1_breq, m2_breq} = s[12:11];
      {m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready} = s[10:7];
      {m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready} = s[6:3];
      {d_rd_bus, d_slave_ready, d_slave_valid} = s[2:0];
   endtask

   task automatic chk_route();
      logic [3:0] ed;
      logic [2:0] e1, e2, dr;
      dr = {d_rd_bus, d_slave_ready, d_slave_valid};
      ed = '0; e1 = '0; e2 = '0;
      if (holder == 0) begin
         ed = {m1_mode, m1_wr_bus, m1_master_valid, m1_master_ready};
         e1 = dr;
      end else if (holder == 1) begin
         ed = {m2_mode, m2_wr_bus, m2_master_valid, m2_master_ready};
         e2 = dr;
      end
      chk("d_bus", 32'({d_mode, d_wr_bus, d_master_valid,
                        d_master_ready}), 32'(ed));
      chk("m1_ret", 32'({m1_rd_bus, m1_slave_ready, m1_slave_valid}),
          32'(e1));
      chk("m2_ret", 32'({m2_rd_bus, m2_slave_ready, m2_slave_valid}),
          32'(e2));
   endtask

   task automatic cycle(input logic [12:0] s);
      @(posedge clk);
      model_step();
      #1;
      chk("m1_bgrant", 32'(m1_bgrant), 32'(holder == 0));
      chk("m2_bgrant", 32'(m2_bgrant), 32'(holder == 1));
      chk("owner", 32'(owner), 32'(own_m));
      chk("timeout_err", 32'(timeout_err), 32'(terr_m));
      drive(s);
      #1;
      chk_route();
   endtask

   task automatic do_reset(input logic [12:0] s);
      rstn = 1'b0;
      model_reset();
      drive(s);
      repeat (2) @(posedge clk);
      #2;
      rstn = 1'b1;
   endtask

   function automatic logic [12:0] rnd(input logic [12:0] p);
      logic [12:0] s;
      s = p;
      if ($urandom_range(7) == 0) s[12] = ~s[12];
      if ($urandom_range(7) == 0) s[11] = ~s[11];
      s[10] = 1'($urandom); s[9] = 1'($urandom);
      s[8] = ($urandom_range(19) == 0);
      s[7] = ($urandom_range(19) == 0);
      s[6] = 1'($urandom); s[5] = 1'($urandom);
      s[4] = ($urandom_range(19) == 0);
      s[3] = ($urandom_range(19) == 0);
      s[2] = 1'($urandom);
      s[1] = ($urandom_range(19) == 0);
      s[0] = ($urandom_range(19) == 0);
      return s;
   endfunction

   always @(negedge clk) begin
      chk("mutex", 32'(m1_bgrant & m2_bgrant), 32'd0);
      if (!m1_bgrant && !m2_bgrant)
         chk("d_idle", 32'({d_mode, d_wr_bus, d_master_valid,
                            d_master_ready}), 32'd0);
   end

   localparam logic [12:0] S_BOTH = 13'b1_1_0010_0010_000;
   localparam logic [12:0] S_M2   = 13'b0_1_0000_0000_000;
   localparam logic [12:0] S_M1TX = 13'b1_0_0110_0000_000;

   initial begin
      logic [12:0] s;
      int n;
      rstn = 1'b0;
      model_reset();
      drive('1);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_bgrant", 32'({m1_bgrant, m2_bgrant}), 32'd0);
      chk("rst_owner", 32'(owner), 32'd0);
      chk("rst_terr", 32'(timeout_err), 32'd0);
      chk_route();

      // tie from reset: master 1 first, then master 2 after its drop
      drive(13'b1_1_0100_0000_000);
      #1 rstn = 1'b1;
      cycle(13'b1_1_0000_0000_000);
      chk("s2_first", 32'(m1_bgrant), 32'd1);
      cycle(13'b1_1_0100_0000_100);
      cycle(13'b0_1_0010_0010_000);
      repeat (3) cycle(13'b0_1_0000_0010_010);
      chk("s2_owner", 32'(owner), 32'd1);

      // alternating round robin
      do_reset(S_BOTH);
      for (int k = 0; k < 4; k++) begin
         repeat (10) cycle(S_BOTH);
         chk("s3_owner", 32'(owner), 32'(k & 1));
         s = S_BOTH;
         if (holder == 0) s[12] = 1'b0;
         else s[11] = 1'b0;
         cycle(s);
      end
      repeat (2) cycle(S_BOTH);

      // silent owner gets revoked and must drop breq first
      do_reset(S_M2);
      n = 0;
      repeat (14) begin
         cycle(S_M2);
         if (timeout_err) n++;
      end
      chk("s4_pulses", 32'(n), 32'd1);
      chk("s4_held", 32'(m2_bgrant), 32'd0);
      cycle('0);
      cycle(S_M2);
      cycle(S_M2);
      chk("s4_regrant", 32'(m2_bgrant), 32'd1);

      // async reset mid-transfer
      do_reset(S_M1TX);
      repeat (3) cycle(S_M1TX);
      #1 rstn = 1'b0;
      model_reset();
      #1;
      chk("s5_bgrant", 32'(m1_bgrant), 32'd0);
      chk("s5_dmv", 32'(d_master_valid), 32'd0);
      @(posedge clk);
      #2;
      drive(S_M2);
      #1 rstn = 1'b1;
      cycle(S_M2);
      chk("s5_m2", 32'(m2_bgrant), 32'd1);

      // random traffic
      do_reset('0);
      s = '0;
      for (int i = 0; i < 2000; i++) begin
         s = rnd(s);
         cycle(s);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
